// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU over WIDTH cycles; busy stalls the pipeline, done pulses once.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]        count;
    logic                 is_div;
    logic                 is_signed;
    logic                 neg_a;
    logic                 neg_b;
    logic                 dbz_r;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;

    logic                 sign_a_in;
    logic                 sign_b_in;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 start_div_zero;
    logic                 last;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    // Signed ops iterate on magnitudes; the original signs are kept for the final fix-up.
    always_comb begin
        sign_a_in      = op[0] & a[WIDTH-1];
        sign_b_in      = op[0] & b[WIDTH-1];
        mag_a          = sign_a_in ? -a : a;
        mag_b          = sign_b_in ? -b : b;
        start_div_zero = op[1] && (b == '0);
        last           = (count == CW'(WIDTH - 1));
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!is_div)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fix = (is_signed && (neg_a ^ neg_b)) ? -acc_step : acc_step;
        quo_fix  = (is_signed && (neg_a ^ neg_b)) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem_fix  = (is_signed && neg_a) ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start && !flush)
                    state_next = start_div_zero ? DONE : RUN;
                else
                    state_next = IDLE;
            end
            RUN: begin
                if (flush)
                    state_next = IDLE;
                else if (last)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result writes are assigned after MTHI/MTLO writes so a completing result wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            dbz_r     <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= state_next;
            if (state == RUN) begin
                if (!flush) begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                    if (last) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        dbz_r <= 1'b0;
                    end
                end
            end else begin
                if (wr_hi)
                    hi <= wdata;
                if (wr_lo)
                    lo <= wdata;
                if (start && !flush) begin
                    is_div    <= op[1];
                    is_signed <= op[0];
                    neg_a     <= sign_a_in;
                    neg_b     <= sign_b_in;
                    count     <= '0;
                    opnd      <= op[1] ? mag_b : mag_a;
                    acc       <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                    dbz_r     <= start_div_zero;
                    if (start_div_zero) begin
                        hi <= a;
                        lo <= '1;
                    end
                end
            end
        end
    end

    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign div_by_zero = dbz_r & done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: per-cycle behavioural model plus directed
// vectors with hand-computed HI/LO values.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int vectors     = 0;
    int miscompares = 0;
    int busy_cycles = 0;

    int           m_left = 0;
    logic         m_done;
    logic         m_dbz;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] p_hi;
    logic [W-1:0] p_lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: returns {hi, lo} for a non-zero-divisor operation.
    function automatic logic [2*W-1:0] ref_result(input logic [1:0] o,
                                                  input logic [W-1:0] x,
                                                  input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [2*W-1:0] res;
        sx = o[0] ? longint'($signed(x)) : longint'(x);
        sy = o[0] ? longint'($signed(y)) : longint'(y);
        if (!o[1]) begin
            res = sx * sy;
        end else begin
            q   = sx / sy;
            r   = sx % sy;
            res = {r[W-1:0], q[W-1:0]};
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model advances on each rising edge from the sampled inputs, then outputs are compared.
    always @(posedge clk) begin
        m_done = 1'b0;
        m_dbz  = 1'b0;
        if (reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_left > 0) begin
            if (flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                end
            end
        end else begin
            if (wr_hi) m_hi = wdata;
            if (wr_lo) m_lo = wdata;
            if (start && !flush) begin
                if (op[1] && b == '0) begin
                    m_hi   = a;
                    m_lo   = '1;
                    m_done = 1'b1;
                    m_dbz  = 1'b1;
                end else begin
                    {p_hi, p_lo} = ref_result(op, a, b);
                    m_left = W;
                end
            end
        end
        #1;
        if (busy) busy_cycles++;
        checkOutput("busy", W'(busy), W'(m_left > 0));
        checkOutput("done", W'(done), W'(m_done));
        checkOutput("div_by_zero", W'(div_by_zero), W'(m_dbz));
        checkOutput("hi", hi, m_hi);
        checkOutput("lo", lo, m_lo);
    end

    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    // Counts rising edges after the start edge until done is seen; bounded.
    task automatic waitDone(input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no done after %0d edges, expected done", cycles);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_busy", W'(busy), 32'h0);
        checkOutput("reset_done", W'(done), 32'h0);
        reset = 1'b0;

        // MTHI / MTLO in IDLE
        @(negedge clk); wr_hi = 1'b1; wdata = 32'h1111;
        @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h2222;
        @(negedge clk); wr_lo = 1'b0;
        checkOutput("mthi", hi, 32'h1111);
        checkOutput("mtlo", lo, 32'h2222);

        // MULTU all ones: latency and busy width
        busy_cycles = 0;
        applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(40, lat);
        checkOutput("multu_latency", W'(lat), 32'd32);
        checkOutput("multu_busy_cycles", W'(busy_cycles), 32'd32);
        checkOutput("multu_hi", hi, 32'hFFFFFFFE);
        checkOutput("multu_lo", lo, 32'h00000001);

        applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5);
        waitDone(40, lat);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFF1);

        applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2);
        waitDone(40, lat);
        checkOutput("div_neg_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_neg_hi", hi, 32'hFFFFFFFF);

        applyStimulus(2'b11, 32'd7, 32'hFFFFFFFE);
        waitDone(40, lat);
        checkOutput("div_negb_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_negb_hi", hi, 32'h00000001);

        applyStimulus(2'b10, 32'd100, 32'd7);
        waitDone(40, lat);
        checkOutput("divu_lo", lo, 32'h0000000E);
        checkOutput("divu_hi", hi, 32'h00000002);

        // Divide by zero goes straight to DONE
        busy_cycles = 0;
        applyStimulus(2'b10, 32'h00001234, 32'h0);
        waitDone(4, lat);
        checkOutput("dbz_latency", W'(lat), 32'd0);
        checkOutput("dbz_flag", W'(div_by_zero), 32'd1);
        checkOutput("dbz_lo", lo, 32'hFFFFFFFF);
        checkOutput("dbz_hi", hi, 32'h00001234);
        @(negedge clk);
        checkOutput("dbz_busy_never", W'(busy_cycles), 32'd0);

        applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF);
        waitDone(40, lat);
        checkOutput("div_ovf_lo", lo, 32'h80000000);
        checkOutput("div_ovf_hi", hi, 32'h00000000);
        checkOutput("div_ovf_flag", W'(div_by_zero), 32'd0);

        // Start together with MTHI in IDLE: write lands, result overwrites later
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; wr_hi = 1'b1; wdata = 32'hBEEF;
        @(posedge clk);
        #2;
        start = 1'b0; wr_hi = 1'b0;
        checkOutput("start_wr_hi", hi, 32'h0000BEEF);
        waitDone(40, lat);
        checkOutput("start_wr_res_hi", hi, 32'h0);
        checkOutput("start_wr_res_lo", lo, 32'h6);

        // Flush mid-operation
        applyStimulus(2'b00, 32'h12345678, 32'h10);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("flush_busy", W'(busy), 32'd0);
        @(negedge clk); flush = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("flush_hi", hi, 32'h0);
        checkOutput("flush_lo", lo, 32'h6);

        // Reset mid-operation
        applyStimulus(2'b00, 32'h12345678, 32'h10);
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checkOutput("midreset_busy", W'(busy), 32'd0);
        checkOutput("midreset_hi", hi, 32'h0);
        checkOutput("midreset_lo", lo, 32'h0);

        // Back-to-back: new start while in DONE
        applyStimulus(2'b00, 32'h12345678, 32'h10);
        waitDone(40, lat);
        checkOutput("b2b_first_hi", hi, 32'h00000001);
        checkOutput("b2b_first_lo", lo, 32'h23456780);
        applyStimulus(2'b10, 32'd1000, 32'd10);
        waitDone(40, lat);
        checkOutput("b2b_latency", W'(lat), 32'd32);
        checkOutput("b2b_lo", lo, 32'd100);
        checkOutput("b2b_hi", hi, 32'd0);

        // MTLO while busy is ignored
        applyStimulus(2'b00, 32'd9, 32'd9);
        @(negedge clk); wr_lo = 1'b1; wdata = 32'hA5;
        @(negedge clk); wr_lo = 1'b0;
        checkOutput("busy_wr_lo", lo, 32'd100);
        waitDone(40, lat);
        checkOutput("busy_wr_res_lo", lo, 32'd81);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
